// File: rtl/isa_pkg.sv
// Core ISA widths and shared types for the fetch side.
// Also carries the program loader state encoding.
package isa;

   localparam int program_counter_length = 16;
   localparam int instruction_length     = 16;

   typedef logic [program_counter_length-1:0] pc_reg_t;
   typedef logic [instruction_length-1:0]     instruction_t;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Host-to-loader byte stream handshake.
// The host is the master; the loader is the slave.
interface imem_loader_if;

   logic       load_valid;
   logic [7:0] load_data;
   logic       load_last;
   logic       load_ready;

   modport master (
      output load_valid,
      output load_data,
      output load_last,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      input  load_last,
      output load_ready
   );

endinterface

// File: rtl/imem_loader_ram.sv
// Instruction memory: one write port, one registered read port.
// Contents are never cleared; only the read register resets.
module imem_ram #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;
   logic [WIDTH-1:0] rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[raddr];
   end

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Program loader + instruction memory responder for the fetch unit.
// Optional IMEM_RELOAD_EN adds a reload input that re-enters LOAD from RUN.
module imem_loader
   import isa::*;
#(
   parameter int IMEM_DEPTH  = 256,
   parameter int INSTR_BYTES = 2
) (
   input  logic         clk,
   input  logic         rst,
`ifdef IMEM_RELOAD_EN
   input  logic         reload,
`endif
   imem_loader_if.slave ld,
   input  pc_reg_t      fetch_pc,
   output instruction_t instruction,
   output logic         core_rst,
   output logic         load_error
);

   localparam int AW = $clog2(IMEM_DEPTH);
   localparam int PW = AW + 1;
   localparam int SH = $clog2(INSTR_BYTES);
   localparam int CW = (INSTR_BYTES > 1) ? SH : 1;

   loader_state_t state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   instruction_t  asm_q, asm_d;
   logic          err_q, err_d;
   logic          zero_q, zero_d;

   logic          load_ready;
   logic          accept;
   logic          full;
   logic          last_byte;
   logic          reload_run;
   instruction_t  merged;
   pc_reg_t       idx;

   logic          we;
   logic          re;
   logic [AW-1:0] raddr;
   instruction_t  rdata;

`ifdef IMEM_RELOAD_EN
   assign reload_run = (state_q == RUN) && reload;
`else
   assign reload_run = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= LOAD;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LOAD:    if (accept && ld.load_last) state_d = START;
         START:   state_d = RUN;
         RUN:     if (reload_run) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   always_comb begin
      load_ready = 1'b0;
      core_rst   = 1'b1;
      unique case (state_q)
         LOAD:    load_ready = 1'b1;
         START:   core_rst   = 1'b1;
         RUN:     core_rst   = 1'b0;
         default: core_rst   = 1'b1;
      endcase
   end

   assign ld.load_ready = load_ready;

   assign accept    = ld.load_valid && load_ready;
   assign full      = (ptr_q == PW'(IMEM_DEPTH));
   assign last_byte = (cnt_q == CW'(INSTR_BYTES - 1));

   // First byte of a word starts from zero so a short final word is padded
   always_comb begin
      merged = (cnt_q == '0) ? '0 : asm_q;
      merged = merged | (instruction_t'(ld.load_data) << {cnt_q, 3'b000});
   end

   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      asm_d = asm_q;
      err_d = err_q;
      we    = 1'b0;
      if (reload_run) begin
         ptr_d = '0;
         cnt_d = '0;
         err_d = 1'b0;
      end else if (accept) begin
         if (full) begin
            err_d = 1'b1;
         end else if (last_byte || ld.load_last) begin
            we    = 1'b1;
            ptr_d = ptr_q + PW'(1);
            cnt_d = '0;
            if (!last_byte) err_d = 1'b1;
         end else begin
            asm_d = merged;
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign idx = fetch_pc >> SH;

   // Core PC is meaningless while it is held in reset, so START reads word 0
   always_comb begin
      re     = 1'b0;
      raddr  = '0;
      zero_d = zero_q;
      if (state_q == START) begin
         re     = 1'b1;
         zero_d = 1'b0;
      end else if (state_q == RUN) begin
         re     = 1'b1;
         raddr  = idx[AW-1:0];
         zero_d = (idx >= pc_reg_t'(IMEM_DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q  <= '0;
         cnt_q  <= '0;
         asm_q  <= '0;
         err_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         cnt_q  <= cnt_d;
         asm_q  <= asm_d;
         err_q  <= err_d;
         zero_q <= zero_d;
      end
   end

   imem_ram #(
      .DEPTH (IMEM_DEPTH),
      .WIDTH (instruction_length)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (ptr_q[AW-1:0]),
      .wdata (merged),
      .re    (re),
      .raddr (raddr),
      .rdata (rdata)
   );

   assign instruction = zero_q ? '0 : rdata;
   assign load_error  = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: host byte streams in, core fetches out.
// Expected fetch results go through a queue scoreboard.
module tb_imem_loader;
   import isa::*;

   localparam int DEPTH = 256;

   logic         clk = 1'b0;
   logic         rst;
   pc_reg_t      fetch_pc;
   instruction_t instruction;
   logic         core_rst;
   logic         load_error;
`ifdef IMEM_RELOAD_EN
   logic         reload;
`endif

   imem_loader_if lif();

   imem_loader #(
      .IMEM_DEPTH  (DEPTH),
      .INSTR_BYTES (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef IMEM_RELOAD_EN
      .reload      (reload),
`endif
      .ld          (lif.slave),
      .fetch_pc    (fetch_pc),
      .instruction (instruction),
      .core_rst    (core_rst),
      .load_error  (load_error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   instruction_t exp_q[$];
   logic [15:0]  model [DEPTH];
   int           nbytes;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      lif.load_valid = 1'b0;
      lif.load_data  = 8'h00;
      lif.load_last  = 1'b0;
      fetch_pc       = '0;
`ifdef IMEM_RELOAD_EN
      reload         = 1'b0;
`endif
      step();
      step();
      rst    = 1'b0;
      nbytes = 0;
      check("rst_ready", lif.load_ready, 1);
      check("rst_core_rst", core_rst, 1);
      check("rst_instr", instruction, 0);
      check("rst_err", load_error, 0);
   endtask

   task automatic send(input logic [7:0] d, input logic last, input int gap);
      int w;
      repeat (gap) step();
      lif.load_valid = 1'b1;
      lif.load_data  = d;
      lif.load_last  = last;
      for (int i = 0; i < 16 && !lif.load_ready; i++) step();
      check("ld_ready", lif.load_ready, 1);
      w = nbytes / 2;
      if (w < DEPTH) begin
         if (nbytes % 2 == 0) model[w] = 16'h0000;
         model[w][8*(nbytes%2) +: 8] = d;
      end
      nbytes++;
      step();
      lif.load_valid = 1'b0;
      lif.load_last  = 1'b0;
   endtask

   // Called right after the edge that accepted load_last
   task automatic start_seq(input string tag, input logic exp_err);
      check({tag, "_start_crst"}, core_rst, 1);
      check({tag, "_start_rdy"}, lif.load_ready, 0);
      fetch_pc = 16'h0002;
      exp_q.push_back(model[0]);
      step();
      check({tag, "_run_crst"}, core_rst, 0);
      check({tag, "_first_instr"}, instruction, exp_q.pop_front());
      check({tag, "_err"}, load_error, exp_err);
   endtask

   task automatic fetch(input string tag, input pc_reg_t pc);
      int w;
      w = int'(pc) / 2;
      fetch_pc = pc;
      exp_q.push_back((w < DEPTH) ? model[w] : 16'h0000);
      step();
      check(tag, instruction, exp_q.pop_front());
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      logic [15:0] wv;

      do_reset();

      // basic two-word program
      send(8'h34, 1'b0, 0);
      send(8'h12, 1'b0, 0);
      send(8'h78, 1'b0, 0);
      send(8'h56, 1'b1, 0);
      check("basic_model0", model[0], 16'h1234);
      start_seq("basic", 1'b0);
      fetch("pc2", 16'd2);
      fetch("pc3_odd", 16'd3);
      fetch("pc_oor", 16'(2 * DEPTH));
      fetch("pc0", 16'd0);

      // host bytes are ignored while running
      lif.load_valid = 1'b1;
      lif.load_data  = 8'hFF;
      lif.load_last  = 1'b1;
      step();
      check("run_not_ready", lif.load_ready, 0);
      check("run_crst_low", core_rst, 0);
      lif.load_valid = 1'b0;
      lif.load_last  = 1'b0;
      fetch("run_ignore_pc0", 16'd0);
      fetch("run_ignore_pc2", 16'd2);

      // truncated final word
      do_reset();
      send(8'h11, 1'b0, 0);
      send(8'h22, 1'b0, 0);
      send(8'hAB, 1'b1, 0);
      start_seq("trunc", 1'b1);
      fetch("trunc_w1", 16'd2);
      fetch("trunc_w0", 16'd0);

      // single-byte program
      do_reset();
      send(8'h5A, 1'b1, 0);
      start_seq("single", 1'b1);
      fetch("single_w0", 16'd1);

      // random gaps between bytes
      do_reset();
      for (int i = 0; i < 8; i++)
         send(8'($urandom), (i == 7), $urandom_range(0, 3));
      start_seq("gaps", 1'b0);
      for (int i = 0; i < 4; i++)
         fetch($sformatf("gaps_w%0d", i), pc_reg_t'(2 * i));

      // overflow: one word more than the memory holds
      do_reset();
      for (int w = 0; w <= DEPTH; w++) begin
         wv = (w == DEPTH) ? 16'hDEAD : (16'hA500 ^ 16'(w));
         send(wv[7:0], 1'b0, 0);
         send(wv[15:8], (w == DEPTH), 0);
      end
      start_seq("ovf", 1'b1);
      fetch("ovf_w0", 16'd0);
      fetch("ovf_wlast", 16'(2 * (DEPTH - 1)));
      fetch("ovf_oor", 16'(2 * DEPTH));

      // reset mid-word, then a fresh program
      do_reset();
      send(8'h99, 1'b0, 0);
      do_reset();
      send(8'hEF, 1'b0, 0);
      send(8'hBE, 1'b1, 0);
      check("rerst_model0", model[0], 16'hBEEF);
      start_seq("rerst", 1'b0);
      fetch("rerst_w0", 16'd0);

`ifdef IMEM_RELOAD_EN
      // reload pulse from RUN, after a run that flagged an error
      do_reset();
      send(8'h01, 1'b1, 0);
      start_seq("rl_pre", 1'b1);
      reload = 1'b1;
      step();
      reload = 1'b0;
      check("reload_crst", core_rst, 1);
      check("reload_ready", lif.load_ready, 1);
      check("reload_err", load_error, 0);
      nbytes = 0;
      send(8'hCD, 1'b0, 0);
      send(8'hAB, 1'b1, 0);
      start_seq("reload", 1'b0);
      fetch("reload_w0", 16'd0);
`endif

      // reset while running
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("runrst_crst", core_rst, 1);
      check("runrst_ready", lif.load_ready, 1);
      check("runrst_instr", instruction, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-memory responder on the far side of the control unit's fetch interface.
- Accepts a program as a byte stream from the host over a valid/ready handshake and packs bytes into instructions.
- Holds the core in reset while loading, then serves `instruction` for every `next_program_counter` with one-cycle registered latency, so `instruction` always matches the core's `program_counter`.

Parameters:
- IMEM_DEPTH, 256, number of instruction words; power of two, at most 2^(program_counter_length-1).
- INSTR_BYTES, 2, bytes per instruction; equals instruction_length/8; the PC step equals INSTR_BYTES.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- load_valid  in  1  host byte valid.
- load_data  in  8  host byte.
- load_last  in  1  marks the final byte of the program; qualified by load_valid.
- load_ready  out  1  block accepts a byte this cycle.
- fetch_pc  in  program_counter_length  connected to the core's next_program_counter.
- instruction  out  instruction_length  instruction at the core's current program_counter.
- core_rst  out  1  drives the core's rst.
- load_error  out  1  sticky: truncated final word or overflow.

Behaviour:
- Reset values: state=LOAD, word_ptr=0, byte_cnt=0, load_ready=1, core_rst=1, instruction=0, load_error=0. Memory contents are not cleared.
- A byte is accepted on a clk edge when load_valid && load_ready.
- States:
  - LOAD: load_ready=1, core_rst=1.
  - Accepted bytes fill a shift/assembly register little-endian: the first byte is bits [7:0].
  - byte_cnt counts 0..INSTR_BYTES-1. When the byte that completes a word is accepted, the word is written to imem[word_ptr] in that same edge, word_ptr increments, and byte_cnt returns to 0.
  - If load_last arrives mid-word, the remaining bytes are zero, the padded word is written, and load_error is set.
  - On an accepted load_last, go to START.
  - Overflow: when word_ptr==IMEM_DEPTH, further bytes are still accepted and discarded, and load_error is set. word_ptr saturates at IMEM_DEPTH (width clog2(IMEM_DEPTH)+1).
  - START: lasts one cycle. load_ready=0, core_rst=1. instruction <= imem[0]. Then go to RUN.
  - RUN: load_ready=0, core_rst=0. Host bytes are ignored.
  - Leaving START, the core's first out-of-reset cycle sees PC=0 and instruction=imem[0].
- Fetch:
  - Read index = fetch_pc >> log2(INSTR_BYTES). Low bits are ignored (odd PC aligns down).
  - Index >= IMEM_DEPTH returns all-zeros.
  - Read is a registered synchronous read: instruction <= imem[idx] every RUN cycle (one-cycle latency).
  - While core_rst=1, fetch_pc is ignored (the core's comb next PC is undefined in reset) and address 0 is used.
- Timing rules:
  - A write and a read to the same word never coincide; writes occur only in LOAD.
  - load_last accepted on the same edge as a word completion is a normal end with no error.
  - rst at any time (mid-word, mid-run) returns to LOAD with counters cleared. Partial words are lost. load_error clears.
  - load_last with an empty program (first byte) writes one padded word.

Optional Feature:
- Macro: IMEM_RELOAD_EN.
- Defined:
  - Adds input port reload (1 bit).
  - A reload pulse in RUN returns to LOAD on the next edge: core_rst=1, word_ptr=0, byte_cnt=0, load_error=0.
  - reload in LOAD or START is ignored.
- Undefined: the port is absent; only rst re-enters LOAD.

Decomposition:
- Package isa supplies:
  - program_counter_length, instruction_length, pc_reg_t, instruction_t.
  - New: loader_state_t enum {LOAD, START, RUN}.
- Sub-module: imem_ram. Single write port, single registered read port, parameterized depth and width; infers block RAM.
- The FSM, byte packer and error logic stay in imem_loader.

Test Plan:
- Load bytes 0x34,0x12,0x78,0x56 (last on 0x56) → imem[0]=0x1234, imem[1]=0x5678, load_error=0. core_rst falls 2 cycles after the last accept. The first core cycle sees instruction=0x1234.
- In RUN, drive fetch_pc=2 → next cycle instruction=0x5678. fetch_pc=3 → 0x5678. fetch_pc=2*IMEM_DEPTH → 0x0000.
- Stream with load_last on the 3rd byte 0xAB → imem[1]=0x00AB, load_error=1, reaches RUN.
- Toggle load_valid randomly with gaps → data is packed identically; no byte is lost or duplicated.
- Load IMEM_DEPTH+1 words → first IMEM_DEPTH stored, load_error=1, imem[0] unchanged.
- Assert rst after 1 byte, then reload 2 bytes 0xEF,0xBE → imem[0]=0xBEEF. With IMEM_RELOAD_EN, a reload pulse in RUN re-asserts core_rst the next cycle.
